// File: rtl/montgomery_mul_cfg.sv
`default_nettype none
// ============================================================================
// montgomery_mul_cfg : radix-2 bit-serial Montgomery multiplier,
//   result = A*B*2^-N mod M, using one W-bit chunk adder reused NC times.
// Revision: 1.0
// ============================================================================
module montgomery_mul_cfg #(
  parameter int N          = 1024,
  parameter int W          = 64,
  parameter bit CONST_TIME = 1'b1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] result
);

  localparam int NC    = (N + 2 + W - 1) / W;
  localparam int CW    = NC * W;
  localparam int CNT_W = (NC > 1) ? $clog2(NC) : 1;
  localparam int I_W   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] C_LAST_CHUNK = CNT_W'(NC - 1);
  localparam logic [I_W-1:0]   C_LAST_BIT   = I_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADD_B = 3'd1,
    S_ADD_M = 3'd2,
    S_SHIFT = 3'd3,
    S_SUB   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_a;      // shifted right each SHIFT: r_a[0] is the current a_i
  logic [CW-1:0]    r_b;
  logic [CW-1:0]    r_m;
  logic [CW-1:0]    r_c;
  logic [CW-1:0]    r_d;
  logic [CNT_W-1:0] r_cnt;
  logic [I_W-1:0]   r_i;
  logic             r_cy;     // carry in add phases, borrow in SUB
  logic             r_q;

  logic [W-1:0]     w_addend;
  logic [W:0]       w_sum;
  logic [W:0]       w_diff;
  logic [CW-1:0]    w_c_add_rot;
  logic [CW-1:0]    w_c_rot;
  logic [CW-1:0]    w_b_rot;
  logic [CW-1:0]    w_m_rot;
  logic [CW-1:0]    w_d_shift;
  logic             w_last_chunk;
  logic             w_q_b;
  logic             w_unused_d;

  // Operands rotate right by one chunk per cycle so the active chunk is
  // always bits [W-1:0]; after NC cycles every register is back in place.
  always_comb begin
    w_addend = '0;
    if (r_state == S_ADD_B) begin
      w_addend = r_b[W-1:0] & {W{r_a[0]}};
    end else if (r_state == S_ADD_M) begin
      w_addend = r_m[W-1:0] & {W{r_q}};
    end
  end

  assign w_sum        = {1'b0, r_c[W-1:0]} + {1'b0, w_addend} + {{W{1'b0}}, r_cy};
  assign w_diff       = {1'b0, r_c[W-1:0]} - {1'b0, r_m[W-1:0]} - {{W{1'b0}}, r_cy};
  assign w_c_add_rot  = (r_c >> W) | (CW'(w_sum[W-1:0]) << (CW - W));
  assign w_c_rot      = (r_c >> W) | (CW'(r_c[W-1:0]) << (CW - W));
  assign w_b_rot      = (r_b >> W) | (CW'(r_b[W-1:0]) << (CW - W));
  assign w_m_rot      = (r_m >> W) | (CW'(r_m[W-1:0]) << (CW - W));
  assign w_d_shift    = (r_d >> W) | (CW'(w_diff[W-1:0]) << (CW - W));
  assign w_last_chunk = (r_cnt == C_LAST_CHUNK);
  // LSB of C after ADD_B: produced by chunk 0, captured in r_q on that cycle
  assign w_q_b        = (r_cnt == '0) ? w_sum[0] : r_q;
  assign w_unused_d   = ^r_d[CW-1:N];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_i     <= '0;
      r_cy    <= 1'b0;
      r_q     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= in_a;
            r_b   <= CW'(in_b);
            r_m   <= CW'(in_m);
            r_c   <= '0;
            r_cnt <= '0;
            r_i   <= '0;
            r_cy  <= 1'b0;
            r_q   <= 1'b0;
            busy  <= 1'b1;
            r_state <= (CONST_TIME || in_a[0]) ? S_ADD_B : S_SHIFT;
          end
        end
        S_ADD_B: begin
          r_c  <= w_c_add_rot;
          r_b  <= w_b_rot;
          r_cy <= w_sum[W];
          if (r_cnt == '0) begin
            r_q <= w_sum[0];
          end
          if (w_last_chunk) begin
            r_cnt   <= '0;
            r_cy    <= 1'b0;
            r_state <= (CONST_TIME || w_q_b) ? S_ADD_M : S_SHIFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ADD_M: begin
          r_c  <= w_c_add_rot;
          r_m  <= w_m_rot;
          r_cy <= w_sum[W];
          if (w_last_chunk) begin
            r_cnt   <= '0;
            r_cy    <= 1'b0;
            r_state <= S_SHIFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          r_c <= r_c >> 1;
          r_a <= r_a >> 1;
          r_i <= r_i + 1'b1;
          if (r_i == C_LAST_BIT) begin
            r_state <= S_SUB;
          end else if (CONST_TIME || r_a[1]) begin
            r_state <= S_ADD_B;
          end else begin
            // ADD_B skipped, so q is the LSB of the shifted C
            r_q     <= r_c[1];
            r_state <= r_c[1] ? S_ADD_M : S_SHIFT;
          end
        end
        S_SUB: begin
          r_d  <= w_d_shift;
          r_c  <= w_c_rot;
          r_m  <= w_m_rot;
          r_cy <= w_diff[W];
          if (w_last_chunk) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          result  <= r_cy ? r_c[N-1:0] : r_d[N-1:0];
          done    <= 1'b1;
          err     <= ~r_m[0];
          busy    <= 1'b0;
          r_cy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_montgomery_mul_cfg.sv
`default_nettype none
// tb_montgomery_mul_cfg : directed and randomized checks of montgomery_mul_cfg
//   (N=8/W=4 and N=1024/W=64, both timing modes) against a modular-arithmetic model.
module tb_montgomery_mul_cfg;

  localparam int MW       = 1024;
  localparam int NI       = 4;
  localparam int C_MAXLAT = 40000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [NI-1:0] st, bz, dn, er;
  logic [MW-1:0] ia [NI];
  logic [MW-1:0] ib [NI];
  logic [MW-1:0] im [NI];
  logic [7:0]    r0, r1;
  logic [MW-1:0] r2, r3;
  logic [MW-1:0] res_v [NI];

  int p_n  [NI] = '{8, 8, 1024, 1024};
  int p_w  [NI] = '{4, 4, 64, 64};
  int p_ct [NI] = '{1, 0, 1, 0};

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  assign res_v[0] = {{(MW-8){1'b0}}, r0};
  assign res_v[1] = {{(MW-8){1'b0}}, r1};
  assign res_v[2] = r2;
  assign res_v[3] = r3;

  montgomery_mul_cfg #(.N(8), .W(4), .CONST_TIME(1'b1)) u_s_ct (
    .clk(clk), .resetn(rstn), .start(st[0]),
    .in_a(ia[0][7:0]), .in_b(ib[0][7:0]), .in_m(im[0][7:0]),
    .busy(bz[0]), .done(dn[0]), .err(er[0]), .result(r0));

  montgomery_mul_cfg #(.N(8), .W(4), .CONST_TIME(1'b0)) u_s_var (
    .clk(clk), .resetn(rstn), .start(st[1]),
    .in_a(ia[1][7:0]), .in_b(ib[1][7:0]), .in_m(im[1][7:0]),
    .busy(bz[1]), .done(dn[1]), .err(er[1]), .result(r1));

  montgomery_mul_cfg #(.N(1024), .W(64), .CONST_TIME(1'b1)) u_l_ct (
    .clk(clk), .resetn(rstn), .start(st[2]),
    .in_a(ia[2]), .in_b(ib[2]), .in_m(im[2]),
    .busy(bz[2]), .done(dn[2]), .err(er[2]), .result(r2));

  montgomery_mul_cfg #(.N(1024), .W(64), .CONST_TIME(1'b0)) u_l_var (
    .clk(clk), .resetn(rstn), .start(st[3]),
    .in_a(ia[3]), .in_b(ib[3]), .in_m(im[3]),
    .busy(bz[3]), .done(dn[3]), .err(er[3]), .result(r3));

  // result = (A*B + Q*M)/2^n reduced below M, with Q = -A*B*M^-1 mod 2^n.
  // Q's bits are exactly the q_i decisions, which sets the variable latency.
  function automatic void ref_model(input logic [MW-1:0] a_in, b_in, m_in,
                                    input int n, w, ct,
                                    output logic [MW-1:0] res, output int lat);
    logic [MW-1:0]   mask, a, b, m, inv, q;
    logic [2*MW+1:0] ab, t, mx;
    int nc;
    nc   = (n + 2 + w - 1) / w;
    mask = '1;
    if (n < MW) mask = (MW'(1) << n) - MW'(1);
    a = a_in & mask;
    b = b_in & mask;
    m = m_in & mask;
    inv = MW'(1);
    for (int it = 0; it < 11; it++) inv = (inv * (MW'(2) - m * inv)) & mask;
    ab = {{(MW+2){1'b0}}, a} * {{(MW+2){1'b0}}, b};
    q  = ((~ab[MW-1:0] + MW'(1)) * inv) & mask;
    mx = {{(MW+2){1'b0}}, m};
    t  = (ab + {{(MW+2){1'b0}}, q} * mx) >> n;
    if (t >= mx) t = t - mx;
    res = t[MW-1:0];
    lat = (ct != 0) ? n * (2 * nc + 1) + nc + 1
                    : n + nc + 1 + nc * ($countones(a) + $countones(q));
  endfunction

  task automatic chk(input string nm, input int k, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d t=%0t actual(low192)=%0h required(low192)=%0h",
               nm, k, $time, act[191:0], exp[191:0]);
    end
  endtask

  // model state, advanced on every rising edge from the inputs the DUT sees
  logic [NI-1:0] m_busy, m_done, m_err, m_known, m_pend_err, m_pend_known;
  int            m_cnt  [NI];
  int            m_lat  [NI];
  logic [MW-1:0] m_res  [NI];
  logic [MW-1:0] m_pend [NI];

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (!rstn) begin
        m_busy[k] = 1'b0; m_done[k] = 1'b0; m_err[k] = 1'b0;
        m_res[k] = '0; m_known[k] = 1'b1; m_cnt[k] = 0;
      end else begin
        m_done[k] = 1'b0;
        m_err[k]  = 1'b0;
        if (m_busy[k]) begin
          m_cnt[k]++;
          if (m_cnt[k] == m_lat[k]) begin
            m_busy[k]  = 1'b0;
            m_done[k]  = 1'b1;
            m_err[k]   = m_pend_err[k];
            m_res[k]   = m_pend[k];
            m_known[k] = m_pend_known[k];
          end
        end else if (st[k]) begin
          ref_model(ia[k], ib[k], im[k], p_n[k], p_w[k], p_ct[k], m_pend[k], m_lat[k]);
          m_pend_err[k]   = ~im[k][0];
          m_pend_known[k] = im[k][0];
          m_busy[k] = 1'b1;
          m_cnt[k]  = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        chk("busy", k, MW'(bz[k]), MW'(m_busy[k]));
        chk("done", k, MW'(dn[k]), MW'(m_done[k]));
        chk("err", k, MW'(er[k]), MW'(m_err[k]));
        if (m_known[k]) chk("result", k, res_v[k], m_res[k]);
      end
    end
  end

  function automatic logic [MW-1:0] rand_wide();
    logic [MW-1:0] v;
    for (int j = 0; j < MW / 32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // call at a falling edge; returns at the falling edge where done is seen
  task automatic run_op(input int k, input logic [MW-1:0] a, b, m, output int lat);
    ia[k] = a; ib[k] = b; im[k] = m; st[k] = 1'b1;
    @(negedge clk);
    st[k] = 1'b0;
    ia[k] = rand_wide(); ib[k] = rand_wide(); im[k] = rand_wide();
    lat = 0;
    while (!dn[k] && lat < C_MAXLAT) begin
      @(negedge clk);
      lat++;
    end
    if (!dn[k]) begin
      n_tests++; n_fail++;
      $display("FAIL timeout inst=%0d waited=%0d cycles", k, lat);
    end
  endtask

  task automatic rand_small(input int k, input int cnt);
    int lat;
    logic [MW-1:0] m, a, b;
    for (int j = 0; j < cnt; j++) begin
      m = MW'(2 * $urandom_range(1, 127) + 1);
      a = MW'($urandom % m[31:0]);
      b = MW'($urandom % m[31:0]);
      run_op(k, a, b, m, lat);
    end
  endtask

  task automatic rand_large(input int k, input int cnt);
    int lat;
    logic [MW-1:0] m, a, b;
    for (int j = 0; j < cnt; j++) begin
      m = rand_wide(); m[MW-1] = 1'b1; m[0] = 1'b1;
      a = rand_wide(); a[MW-1] = 1'b0;
      b = rand_wide(); b[MW-1] = 1'b0;
      run_op(k, a, b, m, lat);
      if (k == 2) chk("lat_1024_ct", k, MW'(lat), MW'(35858));
    end
  endtask

  initial begin
    int lat;
    int c;
    rstn = 1'b0;
    st   = '0;
    for (int k = 0; k < NI; k++) begin ia[k] = '0; ib[k] = '0; im[k] = '0; end
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 0, MW'(bz), MW'(0));
    chk("rst_done", 0, MW'(dn), MW'(0));
    chk("rst_result", 2, r2, '0);
    rstn = 1'b1;
    @(negedge clk);

    run_op(0, 5, 7, 13, lat);
    chk("lat_5x7", 0, MW'(lat), MW'(60));
    chk("res_5x7", 0, MW'(r0), MW'(1));
    chk("err_5x7", 0, MW'(er[0]), MW'(0));

    run_op(0, 12, 12, 13, lat);
    chk("lat_12x12", 0, MW'(lat), MW'(60));
    chk("res_12x12", 0, MW'(r0), MW'(3));

    run_op(1, 0, 7, 13, lat);
    chk("lat_0x7_var", 1, MW'(lat), MW'(12));
    chk("res_0x7_var", 1, MW'(r1), MW'(0));

    run_op(0, 5, 7, 12, lat);
    chk("lat_even_m", 0, MW'(lat), MW'(60));
    chk("err_even_m", 0, MW'(er[0]), MW'(1));

    // start pulsed mid-run with other operands must be ignored
    ia[0] = 5; ib[0] = 7; im[0] = 13; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    c = 0;
    while (!dn[0] && c < 200) begin
      if (c == 20) begin ia[0] = 12; ib[0] = 12; st[0] = 1'b1; end
      else st[0] = 1'b0;
      @(negedge clk);
      c++;
    end
    st[0] = 1'b0;
    chk("lat_ignored_start", 0, MW'(c), MW'(60));
    chk("res_ignored_start", 0, MW'(r0), MW'(1));

    // restart in the done cycle, then reset at cycle 30 of that run
    ia[0] = 3; ib[0] = 9; im[0] = 13; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (30) @(negedge clk);
    chk("busy_before_reset", 0, MW'(bz[0]), MW'(1));
    rstn = 1'b0;
    @(negedge clk);
    chk("busy_after_reset", 0, MW'(bz[0]), MW'(0));
    chk("done_after_reset", 0, MW'(dn[0]), MW'(0));
    chk("result_after_reset", 0, MW'(r0), MW'(0));
    rstn = 1'b1;
    @(negedge clk);

    fork
      rand_small(0, 100);
      rand_small(1, 100);
      rand_large(2, 1);
      rand_large(3, 1);
    join

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
